i2c_init_seq: RTL and testbench

I2C_INIT_SEQ -- requirements
Module: i2c_init_seq

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_init_seq.sv | 166 ++++++++++++++++
 tb/tb_i2c_init_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C init sequencer: ROM word opcodes, FSM states
// and the bit positions of the fields inside a command-ROM word.
package i2c_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_DELAY = 2'b01,
    OP_NOP   = 2'b10,
    OP_END   = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_DELAY,
    ST_FINISH
  } state_e;

  localparam int unsigned OP_HI  = 31;
  localparam int unsigned OP_LO  = 30;
  localparam int unsigned DEV_HI = 23;
  localparam int unsigned DEV_LO = 16;
  localparam int unsigned REG_HI = 15;
  localparam int unsigned REG_LO = 8;
  localparam int unsigned DAT_HI = 7;
  localparam int unsigned DAT_LO = 0;
  localparam int unsigned CNT_HI = 23;
  localparam int unsigned CNT_LO = 0;
  localparam int unsigned CNT_W  = CNT_HI - CNT_LO + 1;

endpackage

// File: rtl/i2c_init_seq.sv
// Walks a command ROM and turns each word into I2C register writes, delays or
// end-of-sequence, retrying NACKed writes up to MAX_RETRY times.
module i2c_init_seq
  import i2c_pkg::*;
#(
  parameter int LINES     = 16,
  parameter int DW        = 32,
  parameter int MAX_RETRY = 3
) (
  input  logic                     clka,
  input  logic                     rsta,
  input  logic                     start,
  output logic [$clog2(LINES)-1:0] rom_addr,
  input  logic [DW-1:0]            rom_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_dev,
  output logic [7:0]               cmd_reg,
  output logic [7:0]               cmd_data,
  input  logic                     rsp_valid,
  input  logic                     rsp_nack,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned AW = $clog2(LINES);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [AW-1:0] LAST_LINE = AW'(LINES - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  state_e          state_q;
  logic [AW-1:0]   ptr_q;
  logic [RW-1:0]   retry_q;
  logic [CNT_W-1:0] dly_q;
  logic            cmd_valid_q;
  logic [7:0]      dev_q;
  logic [7:0]      reg_q;
  logic [7:0]      dat_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;

  opcode_e          op_w;
  logic [CNT_W-1:0] dly_w;
  logic             unused_rom_bits;

  state_e          adv_state_d;
  logic [AW-1:0]   adv_ptr_d;

  assign op_w            = opcode_e'(rom_data[OP_HI:OP_LO]);
  assign dly_w           = rom_data[CNT_HI:CNT_LO];
  assign unused_rom_bits = ^rom_data[29:24];

  // Advancing past the last ROM line ends the sequence instead of wrapping.
  always_comb begin
    adv_state_d = ST_FETCH;
    adv_ptr_d   = ptr_q + 1'b1;
    if (ptr_q == LAST_LINE) begin
      adv_state_d = ST_FINISH;
      adv_ptr_d   = ptr_q;
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      retry_q     <= '0;
      dly_q       <= '0;
      cmd_valid_q <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      dat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            ptr_q   <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          unique case (op_w)
            OP_WRITE: begin
              dev_q       <= rom_data[DEV_HI:DEV_LO];
              reg_q       <= rom_data[REG_HI:REG_LO];
              dat_q       <= rom_data[DAT_HI:DAT_LO];
              retry_q     <= '0;
              cmd_valid_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end
            OP_DELAY: begin
              if (dly_w == '0) begin
                state_q <= adv_state_d;
                ptr_q   <= adv_ptr_d;
              end else begin
                dly_q   <= dly_w;
                state_q <= ST_DELAY;
              end
            end
            OP_NOP: begin
              state_q <= adv_state_d;
              ptr_q   <= adv_ptr_d;
            end
            OP_END: state_q <= ST_FINISH;
          endcase
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_valid) begin
            if (!rsp_nack) begin
              state_q <= adv_state_d;
              ptr_q   <= adv_ptr_d;
            end else if (retry_q < RETRY_LIM) begin
              retry_q     <= retry_q + 1'b1;
              cmd_valid_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end else begin
              error_q <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_DELAY: begin
          // Loaded with N on entry and leaving on 1 gives exactly N cycles here.
          if (dly_q <= CNT_W'(1)) begin
            dly_q   <= '0;
            state_q <= adv_state_d;
            ptr_q   <= adv_ptr_d;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rom_addr  = ptr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_dev   = dev_q;
  assign cmd_reg   = reg_q;
  assign cmd_data  = dat_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq: registered ROM model, I2C master model with
// configurable ready/NACK behaviour, and hand-computed expectations.
module tb_i2c_init_seq;

  localparam int LINES     = 16;
  localparam int DW        = 32;
  localparam int MAX_RETRY = 3;
  localparam int AW        = 4;
  localparam int RSP_LAT   = 3;
  localparam logic [31:0] W_END = 32'hC000_0000;

  logic          clka = 1'b0;
  logic          rsta = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [7:0]    cmd_dev, cmd_reg, cmd_data;
  logic          rsp_valid = 1'b0;
  logic          rsp_nack = 1'b0;
  logic          busy, done, error;

  i2c_init_seq #(.LINES(LINES), .DW(DW), .MAX_RETRY(MAX_RETRY)) dut (
    .clka(clka), .rsta(rsta), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  logic [DW-1:0] rom [0:LINES-1];
  always @(posedge clka) rom_data <= rom[rom_addr];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master model state (written only by the master process)
  int hs_cnt = 0, done_cnt = 0, hold_err = 0, wrap_err = 0;
  int rsp_cd = 0, rsp_idx = 0;
  logic [23:0] hs_pl [0:63];
  int t_a [0:LINES-1];
  bit prev_stall = 1'b0;
  logic [23:0] prev_pl = '0;
  logic [AW-1:0] prev_addr = '0;
  logic prev_busy = 1'b0;

  // Controls written only by the main process
  int ready_mode = 0;   // 0 always ready, 1 never ready, 2 alternating
  int nack_mode = 0;    // 0 ack all, 1 nack first two of run, 2 nack all
  int hs_base = 0;

  initial begin
    forever begin
      @(negedge clka);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      case (ready_mode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = 1'b0;
        default: cmd_ready = ~cmd_ready;
      endcase
      if (rsta) begin
        rsp_cd     = 0;
        prev_stall = 1'b0;
      end else begin
        if (rsp_cd > 0) begin
          rsp_cd--;
          if (rsp_cd == 0) begin
            rsp_valid = 1'b1;
            rsp_nack  = (nack_mode == 2) || (nack_mode == 1 && (rsp_idx - hs_base) < 2);
          end
        end
        if (prev_stall && (!cmd_valid || {cmd_dev, cmd_reg, cmd_data} != prev_pl)) hold_err++;
        prev_stall = cmd_valid && !cmd_ready;
        prev_pl    = {cmd_dev, cmd_reg, cmd_data};
        if (cmd_valid && cmd_ready) begin
          if (hs_cnt < 64) hs_pl[hs_cnt] = prev_pl;
          rsp_idx = hs_cnt;
          hs_cnt++;
          rsp_cd = RSP_LAT;
        end
        if (done) done_cnt++;
        if (prev_busy && busy && prev_addr == AW'(LINES - 1) && rom_addr == '0) wrap_err++;
        if (rom_addr != prev_addr) t_a[rom_addr] = cyc;
        prev_addr = rom_addr;
        prev_busy = busy;
      end
    end
  end

  logic r_done, r_err_done, r_busy_done, r_busy_st, r_err_st;
  logic [AW-1:0] r_addr_done;
  int d0, h0, w0;

  // Called just after a negedge; pulses start and waits (bounded) for done.
  task automatic run_seq(input int budget, input int restart_at);
    hs_base = hs_cnt;
    d0 = done_cnt;
    h0 = hold_err;
    w0 = wrap_err;
    r_done = 1'b0; r_err_done = 1'bx; r_busy_done = 1'bx; r_addr_done = 'x;
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
    r_busy_st = busy;
    r_err_st  = error;
    for (int n = 0; n < budget; n++) begin
      @(negedge clka);
      start = (n == restart_at);
      if (done) begin
        r_done      = 1'b1;
        r_err_done  = error;
        r_busy_done = busy;
        r_addr_done = rom_addr;
        break;
      end
    end
    start = 1'b0;
    repeat (5) @(negedge clka);
  endtask

  task automatic rom_fill_end();
    for (int i = 0; i < LINES; i++) rom[i] = W_END;
  endtask

  bit seen;

  initial begin
    rom_fill_end();
    repeat (3) @(negedge clka);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_payload", {cmd_dev, cmd_reg, cmd_data}, 0);
    rsta = 1'b0;
    repeat (8) @(negedge clka);
    check("idle_busy", busy, 0);
    check("idle_no_hs", hs_cnt, 0);

    // Two writes then END, always ready, always ACK
    rom[0] = 32'h0072_4110;
    rom[1] = 32'h0072_9803;
    rom[2] = W_END;
    ready_mode = 0; nack_mode = 0;
    run_seq(200, -1);
    check("basic_busy_at_start", r_busy_st, 1);
    check("basic_done_seen", r_done, 1);
    check("basic_hs_count", hs_cnt - hs_base, 2);
    check("basic_hs0", hs_pl[hs_base], 32'h72_4110);
    check("basic_hs1", hs_pl[hs_base + 1], 32'h72_9803);
    check("basic_err_at_done", r_err_done, 0);
    check("basic_busy_at_done", r_busy_done, 0);
    check("basic_done_once", done_cnt - d0, 1);

    // Zero-length delay acts as NOP, then a 100-cycle delay; stray start ignored
    rom_fill_end();
    rom[0] = 32'h0072_4110;
    rom[1] = 32'h4000_0000;
    rom[2] = 32'h4000_0064;
    rom[3] = 32'h0072_9803;
    run_seq(300, 50);
    check("delay_done_seen", r_done, 1);
    check("delay_hs_count", hs_cnt - hs_base, 2);
    check("delay_hs1", hs_pl[hs_base + 1], 32'h72_9803);
    check("delay0_fetch_gap", t_a[2] - t_a[1], 2);
    check("delay100_fetch_gap", t_a[3] - t_a[2], 102);
    check("delay_done_once", done_cnt - d0, 1);

    // First write NACKed twice then ACKed
    rom_fill_end();
    rom[0] = 32'h0072_4110;
    rom[1] = 32'h0072_9803;
    nack_mode = 1;
    run_seq(200, -1);
    check("retry_done_seen", r_done, 1);
    check("retry_hs_count", hs_cnt - hs_base, 4);
    check("retry_hs1_same", hs_pl[hs_base + 1], 32'h72_4110);
    check("retry_hs2_same", hs_pl[hs_base + 2], 32'h72_4110);
    check("retry_hs3_next", hs_pl[hs_base + 3], 32'h72_9803);
    check("retry_err_at_done", r_err_done, 0);

    // Every attempt NACKed: one issue plus MAX_RETRY re-issues, then error
    nack_mode = 2;
    run_seq(200, -1);
    check("fail_done_seen", r_done, 1);
    check("fail_hs_count", hs_cnt - hs_base, 4);
    check("fail_err_at_done", r_err_done, 1);
    check("fail_busy_at_done", r_busy_done, 0);
    check("fail_err_sticky", error, 1);
    nack_mode = 0;
    run_seq(200, -1);
    check("fail_err_cleared_by_start", r_err_st, 0);
    check("fail_rerun_hs_count", hs_cnt - hs_base, 2);
    check("fail_rerun_err_at_done", r_err_done, 0);

    // Sixteen writes, no END word, alternating ready
    for (int i = 0; i < LINES; i++) rom[i] = 32'h0050_0000 | (i << 8) | (32'hA0 + i);
    ready_mode = 2;
    run_seq(600, -1);
    check("full_done_seen", r_done, 1);
    check("full_hs_count", hs_cnt - hs_base, 16);
    check("full_hs15", hs_pl[hs_base + 15], 32'h50_0FAF);
    check("full_addr_at_done", r_addr_done, 15);
    check("full_no_wrap", wrap_err - w0, 0);
    check("full_payload_held", hold_err - h0, 0);
    check("full_done_once", done_cnt - d0, 1);

    // Reset in the middle of a stalled handshake
    rom_fill_end();
    rom[0] = 32'h8000_0000;
    rom[1] = 32'h8000_0000;
    rom[2] = 32'h0033_5577;
    ready_mode = 1;
    hs_base = hs_cnt;
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clka);
      seen = cmd_valid;
    end
    check("stall_valid_seen", seen, 1);
    check("stall_addr", rom_addr, 2);
    repeat (3) @(negedge clka);
    check("stall_payload", {cmd_dev, cmd_reg, cmd_data}, 32'h33_5577);
    #2 rsta = 1'b1;
    #1;
    check("async_rst_valid", cmd_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_addr", rom_addr, 0);
    check("async_rst_payload", {cmd_dev, cmd_reg, cmd_data}, 0);
    @(negedge clka);
    @(negedge clka);
    rsta = 1'b0;
    ready_mode = 0;
    repeat (10) @(negedge clka);
    check("post_rst_idle", busy, 0);
    check("post_rst_no_hs", hs_cnt - hs_base, 0);

    rom[0] = 32'h0072_4110;
    rom[1] = 32'h0072_9803;
    rom[2] = W_END;
    run_seq(200, -1);
    check("recover_hs_count", hs_cnt - hs_base, 2);
    check("recover_hs0", hs_pl[hs_base], 32'h72_4110);
    check("recover_err_at_done", r_err_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
